// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: {ca,su} = a + b + cin, computed CHUNK bits per clock, LSB first,
// with a start/busy/done handshake and one carry flop linking the chunks.
module serial_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] su,
    output logic             ca,
    output logic             ov
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $fatal(1, "serial_chunk_adder: CHUNK must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] su_q, su_d;
    logic             ca_q, ca_d;
    logic             ov_q, ov_d;

    logic [CHUNK-1:0] chunk_s;
    logic             chunk_c;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        {chunk_c, chunk_s} = {1'b0, a_sh_q[CHUNK-1:0]}
                           + {1'b0, b_sh_q[CHUNK-1:0]}
                           + {{CHUNK{1'b0}}, carry_q};
    end

    // Each chunk sum enters the result from the top, so after N chunks bit 0 is back at the LSB.
    generate
        if (CHUNK == WIDTH) begin : g_single_chunk
            assign res_shift = chunk_s;
        end else begin : g_multi_chunk
            assign res_shift = {chunk_s, res_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        su_d    = su_q;
        ca_d    = ca_q;
        ov_d    = ov_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_sh_d  = a_sh_q >> CHUNK;
                b_sh_d  = b_sh_q >> CHUNK;
                res_d   = res_shift;
                carry_d = chunk_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // Operand MSBs were saved at acceptance since the shift registers lose them.
                    su_d    = res_shift;
                    ca_d    = chunk_c;
                    ov_d    = (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            su_q    <= '0;
            ca_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            su_q    <= su_d;
            ca_q    <= ca_d;
            ov_q    <= ov_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);
    assign su   = su_q;
    assign ca   = ca_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: three configurations (1/1, 8/1, 8/4) driven in sequence,
// expected results queued at stimulus time and compared when done is observed.
module tb_serial_chunk_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_v;
    logic [7:0] a, b;
    logic       cin;

    always #5 clk = ~clk;

    logic       busy1, done1, ca1, ov1;
    logic [0:0] su1;
    logic       busy8, done8, ca8, ov8;
    logic [7:0] su8;
    logic       busy4, done4, ca4, ov4;
    logic [7:0] su4;

    serial_chunk_adder #(.WIDTH(1), .CHUNK(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a[0:0]), .b(b[0:0]), .cin(cin),
        .busy(busy1), .done(done1), .su(su1), .ca(ca1), .ov(ov1)
    );

    serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b), .cin(cin),
        .busy(busy8), .done(done8), .su(su8), .ca(ca8), .ov(ov8)
    );

    serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a), .b(b), .cin(cin),
        .busy(busy4), .done(done4), .su(su4), .ca(ca4), .ov(ov4)
    );

    typedef struct packed {
        logic [7:0] su;
        logic       ca;
        logic       ov;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur   = 0;

    logic       o_busy, o_done, o_ca, o_ov;
    logic [7:0] o_su;

    always_comb begin
        case (cur)
            0:       begin o_busy = busy1; o_done = done1; o_su = {7'b0, su1}; o_ca = ca1; o_ov = ov1; end
            1:       begin o_busy = busy8; o_done = done8; o_su = su8;         o_ca = ca8; o_ov = ov8; end
            default: begin o_busy = busy4; o_done = done4; o_su = su4;         o_ca = ca4; o_ov = ov4; end
        endcase
    end

    function automatic res_t model(input int w, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        res_t       r;
        logic [8:0] s;
        if (w == 1) begin
            s    = 9'(av[0]) + 9'(bv[0]) + 9'(cv);
            r.su = {7'b0, s[0]};
            r.ca = s[1];
            r.ov = (av[0] == bv[0]) && (s[0] != av[0]);
        end else begin
            s    = {1'b0, av} + {1'b0, bv} + 9'(cv);
            r.su = s[7:0];
            r.ca = s[8];
            r.ov = (av[7] == bv[7]) && (s[7] != av[7]);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One addition on DUT 'sel'; glitch_at pulses start at that busy cycle, rst_at aborts with reset.
    task automatic run_add(input int sel, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           input int n, input int glitch_at, input int rst_at);
        res_t e;
        int   done_cnt = 0;
        int   busy_cnt = 0;
        int   done_at  = 0;
        bit   aborted  = 0;
        cur = sel;
        @(negedge clk);
        a = av; b = bv; cin = cv;
        start_v = '0;
        start_v[sel] = 1'b1;
        exp_q.push_back(model(sel == 0 ? 1 : 8, av, bv, cv));
        @(negedge clk);
        start_v = '0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        if (o_busy) busy_cnt++;
        for (int j = 1; j <= n + 4; j++) begin
            @(negedge clk);
            if (j == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", 9'(o_busy), 9'd0);
                chk("abort_done", 9'(o_done), 9'd0);
                chk("abort_su",   9'(o_su),   9'd0);
                chk("abort_ca",   9'(o_ca),   9'd0);
                chk("abort_ov",   9'(o_ov),   9'd0);
                void'(exp_q.pop_back());
                aborted = 1;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                if (o_busy) busy_cnt++;
                if (o_done) begin
                    done_cnt++;
                    if (done_cnt == 1) done_at = j;
                end
            end
            start_v[sel] = (j + 1 == glitch_at);
            if (j + 1 == glitch_at) begin
                a = 8'hFF; b = 8'hFF;
            end
        end
        if (aborted) begin
            chk("no_done_after_abort", 9'(done_cnt), 9'd0);
            chk("idle_after_abort",    9'(o_busy),   9'd0);
        end else begin
            e = exp_q.pop_front();
            chk("done_latency", 9'(done_at),  9'(n));
            chk("busy_cycles",  9'(busy_cnt), 9'(n));
            chk("done_pulses",  9'(done_cnt), 9'd1);
            chk("su",           9'(o_su),     9'(e.su));
            chk("ca",           9'(o_ca),     9'(e.ca));
            chk("ov",           9'(o_ov),     9'(e.ov));
            chk("done_low_after", 9'(o_done), 9'd0);
        end
        $display("add dut=%0d a=%02h b=%02h cin=%0d -> su=%02h ca=%0d ov=%0d done_at=%0d%s",
                 sel, av, bv, cv, o_su, o_ca, o_ov, done_at, aborted ? " (aborted)" : "");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        a = 8'h00; b = 8'h00; cin = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            cur = s;
            #1;
            chk("rst_busy", 9'(o_busy), 9'd0);
            chk("rst_done", 9'(o_done), 9'd0);
            chk("rst_su",   9'(o_su),   9'd0);
            chk("rst_ca",   9'(o_ca),   9'd0);
            chk("rst_ov",   9'(o_ov),   9'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 registered full adder
        run_add(0, 8'h00, 8'h00, 1'b0, 1, 0, 0);
        run_add(0, 8'h00, 8'h01, 1'b0, 1, 0, 0);
        run_add(0, 8'h01, 8'h00, 1'b0, 1, 0, 0);
        run_add(0, 8'h01, 8'h01, 1'b0, 1, 0, 0);
        run_add(0, 8'h01, 8'h01, 1'b1, 1, 0, 0);

        // WIDTH=8, CHUNK=1
        run_add(1, 8'hFF, 8'h01, 1'b0, 8, 0, 0);
        run_add(1, 8'h7F, 8'h01, 1'b0, 8, 0, 0);
        run_add(1, 8'h80, 8'h80, 1'b1, 8, 0, 0);

        // WIDTH=8, CHUNK=4
        run_add(2, 8'hA5, 8'h5A, 1'b1, 2, 0, 0);
        run_add(2, 8'h3C, 8'h4B, 1'b0, 2, 0, 0);
        run_add(2, 8'h9E, 8'hC7, 1'b1, 2, 0, 0);

        // start pulsed mid-addition is ignored
        run_add(1, 8'h03, 8'h04, 1'b0, 8, 3, 0);

        // reset mid-addition aborts, then a fresh add completes
        run_add(1, 8'h12, 8'h34, 1'b0, 8, 0, 4);
        run_add(1, 8'h5A, 8'h33, 1'b1, 8, 0, 0);

        for (int i = 0; i < 3; i++) begin
            run_add(1, 8'($urandom), 8'($urandom), 1'($urandom), 8, 0, 0);
            run_add(2, 8'($urandom), 8'($urandom), 1'($urandom), 2, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
